// File: rtl/detector_scan_ctrl.sv
// Serialises a parallel word into an external Moore "1001" detector, owns its reset and counts hits.
// Optional macro DETECTOR_SCAN_FIRST_HIT_EN adds first_hit_pos (1-based index of the bit completing the first hit).

module detector_scan_ctrl #(
  parameter int WIDTH     = 16,
  parameter int CNT_W     = 5,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           hit_count,
`ifdef DETECTOR_SCAN_FIRST_HIT_EN
  output logic [$clog2(WIDTH+1)-1:0] first_hit_pos,
`endif
  output logic                       det_x,
  output logic                       det_rst,
  input  logic                       det_y
);

  localparam int POS_W = $clog2(WIDTH + 1);
  localparam logic [POS_W-1:0] LAST_BIT = POS_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] shift_reg;
  logic [POS_W-1:0] bit_cnt;
  logic             head_bit;
  logic             fsm_det_rst;
  logic             accept;
  logic             hit_now;

  assign head_bit = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
  assign accept   = (state == IDLE) && start;

  // Detector reset follows system reset immediately, independent of the FSM.
  assign det_rst = reset | fsm_det_rst;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and outputs decoded from the registered state.
  always_comb begin
    next_state  = state;
    busy        = 1'b0;
    done        = 1'b0;
    det_x       = 1'b0;
    fsm_det_rst = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = CLEAR;
        end else begin
          next_state = IDLE;
        end
      end
      CLEAR: begin
        busy        = 1'b1;
        fsm_det_rst = 1'b1;
        next_state  = SHIFT;
      end
      SHIFT: begin
        busy  = 1'b1;
        det_x = head_bit;
        if (bit_cnt == LAST_BIT) begin
          next_state = DRAIN;
        end else begin
          next_state = SHIFT;
        end
      end
      DRAIN: begin
        busy       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // det_y lags det_x by one cycle: skip SHIFT cycle 0, and DRAIN picks up the final bit.
  always_comb begin
    hit_now = 1'b0;
    if (det_y && (state == SHIFT) && (bit_cnt != {POS_W{1'b0}})) begin
      hit_now = 1'b1;
    end else if (det_y && (state == DRAIN)) begin
      hit_now = 1'b1;
    end else begin
      hit_now = 1'b0;
    end
  end

  // Shift register and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= {WIDTH{1'b0}};
      bit_cnt   <= {POS_W{1'b0}};
    end else if (accept) begin
      shift_reg <= data_in;
      bit_cnt   <= {POS_W{1'b0}};
    end else if (state == SHIFT) begin
      if (MSB_FIRST) begin
        shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
      end else begin
        shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
      end
      bit_cnt <= bit_cnt + POS_W'(1);
    end
  end

  // Saturating hit counter; bit_cnt equals the 1-based index of the bit that completed the hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count <= {CNT_W{1'b0}};
`ifdef DETECTOR_SCAN_FIRST_HIT_EN
      first_hit_pos <= {POS_W{1'b0}};
`endif
    end else if (accept) begin
      hit_count <= {CNT_W{1'b0}};
`ifdef DETECTOR_SCAN_FIRST_HIT_EN
      first_hit_pos <= {POS_W{1'b0}};
`endif
    end else if (hit_now) begin
      if (hit_count != {CNT_W{1'b1}}) begin
        hit_count <= hit_count + CNT_W'(1);
      end
`ifdef DETECTOR_SCAN_FIRST_HIT_EN
      if (hit_count == {CNT_W{1'b0}}) begin
        first_hit_pos <= bit_cnt;
      end
`endif
    end
  end

endmodule

// File: tb/tb_detector_scan_ctrl.sv
// Bench for detector_scan_ctrl with a behavioural "1001" Moore detector attached.
// Expected hits are derived by scanning the word directly for 1001 windows.

module tb_detector_scan_ctrl;

  localparam int W     = 16;
  localparam int CNT_W = 5;
  localparam int POS_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [W-1:0]     data_in = '0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_count;
  logic             det_x;
  logic             det_rst;
  logic             det_y;
`ifdef DETECTOR_SCAN_FIRST_HIT_EN
  logic [POS_W-1:0] first_hit_pos;
`endif

  int checks = 0;
  int errors = 0;

  detector_scan_ctrl #(.WIDTH(W), .CNT_W(CNT_W), .MSB_FIRST(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .hit_count (hit_count),
`ifdef DETECTOR_SCAN_FIRST_HIT_EN
    .first_hit_pos (first_hit_pos),
`endif
    .det_x     (det_x),
    .det_rst   (det_rst),
    .det_y     (det_y)
  );

  always #5 clk = ~clk;

  // External Moore detector: y is high when the last four consumed bits are 1001.
  logic [3:0] hist;
  always_ff @(posedge clk or posedge det_rst) begin
    if (det_rst) hist <= 4'b0000;
    else         hist <= {hist[2:0], det_x};
  end
  assign det_y = (hist == 4'b1001);

  // Bit k (1-based) of the word in MSB-first scan order.
  function automatic bit seq_bit(input logic [W-1:0] w, input int k);
    return w[W-k];
  endfunction

  function automatic int ref_hits(input logic [W-1:0] w);
    int n = 0;
    for (int i = 4; i <= W; i++)
      if (seq_bit(w, i-3) && !seq_bit(w, i-2) && !seq_bit(w, i-1) && seq_bit(w, i)) n++;
    if (n > (1 << CNT_W) - 1) n = (1 << CNT_W) - 1;
    return n;
  endfunction

  function automatic int ref_first(input logic [W-1:0] w);
    for (int i = 4; i <= W; i++)
      if (seq_bit(w, i-3) && !seq_bit(w, i-2) && !seq_bit(w, i-1) && seq_bit(w, i)) return i;
    return 0;
  endfunction

  // One full scan; checks {busy,done,det_rst,det_x} every cycle then the results.
  task automatic run_scan(input logic [W-1:0] word, input int inject_at,
                          input bit start_in_done, input string name);
    logic [3:0] got;
    logic [3:0] exp;
    int eh;
    int ef;
    eh = ref_hits(word);
    ef = ref_first(word);
    @(negedge clk);
    start   = 1'b1;
    data_in = word;
    @(negedge clk);
    start   = 1'b0;
    data_in = W'($urandom);
    for (int j = 1; j <= W + 4; j++) begin
      if (j > 1) @(negedge clk);
      if (j == 1)            exp = 4'b1010;
      else if (j <= W + 1)   exp = {3'b100, word[W-1-(j-2)]};
      else if (j == W + 2)   exp = 4'b1000;
      else if (j == W + 3)   exp = 4'b0100;
      else                   exp = 4'b0000;
      got = {busy, done, det_rst, det_x};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d {busy,done,det_rst,det_x}: got %b expected %b", name, j, got, exp);
      end
      if (j == inject_at) begin
        start   = 1'b1;
        data_in = 16'hFFFF;
      end else if (start_in_done && j == W + 3) begin
        start   = 1'b1;
        data_in = 16'h9000;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (hit_count !== CNT_W'(eh)) begin
      errors++;
      $display("FAIL %s hit_count: got %0d expected %0d (word %h)", name, hit_count, eh, word);
    end
`ifdef DETECTOR_SCAN_FIRST_HIT_EN
    checks++;
    if (first_hit_pos !== POS_W'(ef)) begin
      errors++;
      $display("FAIL %s first_hit_pos: got %0d expected %0d (word %h)", name, first_hit_pos, ef, word);
    end
`else
    if (ef < 0) $display("unreachable");
`endif
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, det_rst, det_x} !== 4'b0010 || hit_count !== '0) begin
      errors++;
      $display("FAIL reset_state: got %b/%0d expected 0010/0", {busy, done, det_rst, det_x}, hit_count);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, det_rst, det_x} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: got %b expected 0000", {busy, done, det_rst, det_x});
    end
  endtask

  task automatic test_directed();
    run_scan(16'h9000, -1, 1'b0, "w9000");
    run_scan(16'h9249, -1, 1'b0, "w9249");
    run_scan(16'h0000, -1, 1'b0, "w0000");
    run_scan(16'hFFFF, -1, 1'b0, "wFFFF");
    run_scan(16'h9000, -1, 1'b0, "w9000_prev");
    run_scan(16'h0009, -1, 1'b0, "w0009");
  endtask

  task automatic test_busy_ignore();
    run_scan(16'h9249, 7, 1'b0, "start_while_busy");
    run_scan(16'h0009, -1, 1'b1, "start_in_done");
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'h9249;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || hit_count !== '0 || det_rst !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid busy/hit/det_rst/done: got %b/%0d/%b/%b expected 0/0/1/0",
               busy, hit_count, det_rst, done);
    end
`ifdef DETECTOR_SCAN_FIRST_HIT_EN
    checks++;
    if (first_hit_pos !== '0) begin
      errors++;
      $display("FAIL reset_mid first_hit_pos: got %0d expected 0", first_hit_pos);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, det_rst, det_x} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_idle: got %b expected 0000", {busy, done, det_rst, det_x});
    end
    run_scan(16'h9000, -1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    for (int i = 0; i < 24; i++) begin
      w = W'($urandom);
      if (i % 2 == 1) w = w & W'($urandom);
      if (i % 4 == 2) w = w | 16'h9249;
      run_scan(w, (i % 3 == 0) ? int'($urandom_range(2, W + 1)) : -1, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_mid_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
